// File: rtl/mem_rd_router.sv
// Routes a 16-lane index vector onto 16 single-port banks and steers the returned bank words
// back to their lanes, with tag/valid/done alignment and conflict/throughput status.
module mem_rd_router #(
  parameter int unsigned MA_W   = 6,
  parameter int unsigned BN_W   = 4,
  parameter int unsigned D_W    = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_en,
  input  logic [16*MA_W-1:0]   in_ma,
  input  logic [16*BN_W-1:0]   in_bn,
  input  logic [D_W-1:0]       in_l,
  input  logic                 in_done,
  output logic [15:0]          bank_re,
  output logic [16*MA_W-1:0]   bank_addr,
  input  logic [16*DATA_W-1:0] bank_rdata,
  output logic [16*DATA_W-1:0] lane_data,
  output logic                 lane_valid,
  output logic [D_W-1:0]       lane_l,
  output logic                 done_out,
  output logic                 conflict_err,
  output logic [15:0]          vec_cnt
);

  localparam int unsigned DlDepth = RD_LAT + 1;

  logic [15:0]          re_d;
  logic [16*MA_W-1:0]   addr_d;
  logic                 conflict_d;
  logic [16*DATA_W-1:0] route_d;

  logic [DlDepth-1:0]                 v_dl;
  logic [DlDepth-1:0]                 done_dl;
  logic [DlDepth-1:0][16*BN_W-1:0]    bn_dl;
  logic [DlDepth-1:0][D_W-1:0]        l_dl;

  // Request decode: unreferenced banks keep their last address.
  always_comb begin
    re_d       = '0;
    addr_d     = bank_addr;
    conflict_d = 1'b0;
    if (in_en) begin
      for (int b = 0; b < 16; b++) begin
        // Scan top-down so the lowest-numbered lane is the last writer and wins.
        for (int i = 15; i >= 0; i--) begin
          if (in_bn[i*BN_W +: BN_W] == BN_W'(b)) begin
            re_d[b]                  = 1'b1;
            addr_d[b*MA_W +: MA_W]   = in_ma[i*MA_W +: MA_W];
          end
        end
      end
      for (int i = 0; i < 16; i++) begin
        for (int j = i + 1; j < 16; j++) begin
          if (in_bn[i*BN_W +: BN_W] == in_bn[j*BN_W +: BN_W]) begin
            conflict_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_re      <= '0;
      bank_addr    <= '0;
      conflict_err <= 1'b0;
      vec_cnt      <= '0;
    end else begin
      bank_re   <= re_d;
      bank_addr <= addr_d;
      if (conflict_d) begin
        conflict_err <= 1'b1;
      end
      if (in_en && (vec_cnt != 16'hFFFF)) begin
        vec_cnt <= vec_cnt + 16'd1;
      end
    end
  end

  // Stage k of the delay line is visible k+1 cycles after the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_dl    <= '0;
      done_dl <= '0;
      bn_dl   <= '0;
      l_dl    <= '0;
    end else begin
      v_dl[0]    <= in_en;
      done_dl[0] <= in_done;
      if (in_en) begin
        bn_dl[0] <= in_bn;
        l_dl[0]  <= in_l;
      end
      for (int k = 1; k < DlDepth; k++) begin
        v_dl[k]    <= v_dl[k-1];
        done_dl[k] <= done_dl[k-1];
        bn_dl[k]   <= bn_dl[k-1];
        l_dl[k]    <= l_dl[k-1];
      end
    end
  end

  // Bank word for each lane, selected by the bank index that travelled with it.
  always_comb begin
    route_d = '0;
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 16; b++) begin
        if (bn_dl[RD_LAT][i*BN_W +: BN_W] == BN_W'(b)) begin
          route_d[i*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_data  <= '0;
      lane_valid <= 1'b0;
      lane_l     <= '0;
      done_out   <= 1'b0;
    end else begin
      lane_valid <= v_dl[RD_LAT];
      done_out   <= done_dl[RD_LAT];
      if (v_dl[RD_LAT]) begin
        lane_data <= route_d;
        lane_l    <= l_dl[RD_LAT];
      end
    end
  end

endmodule

// File: tb/tb_mem_rd_router.sv
// Bench for mem_rd_router: RD_LAT=1 and RD_LAT=3 instances share stimulus and are checked every
// cycle against an input-history model, plus literal expectations for the directed cases.
module tb_mem_rd_router;

  localparam int MA_W   = 6;
  localparam int BN_W   = 4;
  localparam int D_W    = 4;
  localparam int DATA_W = 64;
  localparam int HN     = 1024;

  logic                 clk;
  logic                 rst;
  logic                 in_en;
  logic [16*MA_W-1:0]   in_ma;
  logic [16*BN_W-1:0]   in_bn;
  logic [D_W-1:0]       in_l;
  logic                 in_done;

  logic [15:0]          re1, re3;
  logic [16*MA_W-1:0]   addr1, addr3;
  logic [16*DATA_W-1:0] rdata1, rdata3, data1, data3;
  logic                 valid1, valid3, done1, done3, conf1, conf3;
  logic [D_W-1:0]       l1, l3;
  logic [15:0]          cnt1, cnt3;

  mem_rd_router #(.MA_W(MA_W), .BN_W(BN_W), .D_W(D_W), .DATA_W(DATA_W), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_en(in_en), .in_ma(in_ma), .in_bn(in_bn), .in_l(in_l),
    .in_done(in_done), .bank_re(re1), .bank_addr(addr1), .bank_rdata(rdata1),
    .lane_data(data1), .lane_valid(valid1), .lane_l(l1), .done_out(done1),
    .conflict_err(conf1), .vec_cnt(cnt1)
  );

  mem_rd_router #(.MA_W(MA_W), .BN_W(BN_W), .D_W(D_W), .DATA_W(DATA_W), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_en(in_en), .in_ma(in_ma), .in_bn(in_bn), .in_l(in_l),
    .in_done(in_done), .bank_re(re3), .bank_addr(addr3), .bank_rdata(rdata3),
    .lane_data(data3), .lane_valid(valid3), .lane_l(l3), .done_out(done3),
    .conflict_err(conf3), .vec_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank models: word = 100 + addr, garbage when not read, RD_LAT cycles after bank_re.
  logic [16*DATA_W-1:0] bk1_q;
  logic [16*DATA_W-1:0] bk3_q [3];
  assign rdata1 = bk1_q;
  assign rdata3 = bk3_q[2];

  always @(posedge clk) begin
    for (int b = 0; b < 16; b++) begin
      bk1_q[b*DATA_W +: DATA_W] <= re1[b] ? 64'(100 + addr1[b*MA_W +: MA_W]) : 64'hDEAD_BEEF_0000_0000;
      bk3_q[0][b*DATA_W +: DATA_W] <= re3[b] ? 64'(100 + addr3[b*MA_W +: MA_W]) : 64'hDEAD_BEEF_0000_0000;
    end
    bk3_q[1] <= bk3_q[0];
    bk3_q[2] <= bk3_q[1];
  end

  // Input history, one entry per rising edge.
  int                 cyc = 0;
  int                 last_rst = -1;
  logic               h_en   [HN];
  logic               h_done [HN];
  logic [16*MA_W-1:0] h_ma   [HN];
  logic [16*BN_W-1:0] h_bn   [HN];
  logic [D_W-1:0]     h_l    [HN];

  always @(posedge clk) begin
    if (cyc < HN) begin
      h_en[cyc]   <= in_en && !rst;
      h_done[cyc] <= in_done && !rst;
      h_ma[cyc]   <= in_ma;
      h_bn[cyc]   <= in_bn;
      h_l[cyc]    <= in_l;
    end
    if (rst) last_rst <= cyc;
    cyc <= cyc + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] used_mask(input logic [16*BN_W-1:0] bn);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[int'(bn[i*BN_W +: BN_W])] = 1'b1;
    return m;
  endfunction

  function automatic logic [MA_W-1:0] first_ma(input logic [16*MA_W-1:0] ma,
                                               input logic [16*BN_W-1:0] bn, input int b);
    for (int i = 0; i < 16; i++) begin
      if (int'(bn[i*BN_W +: BN_W]) == b) return ma[i*MA_W +: MA_W];
    end
    return '0;
  endfunction

  logic [16*MA_W-1:0]   m_addr [2];
  logic [16*DATA_W-1:0] m_data [2];
  logic [D_W-1:0]       m_l    [2];
  logic                 m_conf [2];
  logic [15:0]          m_cnt  [2];

  task automatic check_dut(input int k, input int lat, input logic [15:0] re,
                           input logic [16*MA_W-1:0] addr, input logic [16*DATA_W-1:0] data,
                           input logic valid, input logic [D_W-1:0] l, input logic done,
                           input logic conf, input logic [15:0] cnt);
    int          le, s;
    logic        v, dn;
    logic [15:0] ere;
    le = cyc - 1;
    ere = '0;
    v = 1'b0;
    dn = 1'b0;
    if (rst) begin
      m_addr[k] = '0;
      m_data[k] = '0;
      m_l[k]    = '0;
      m_conf[k] = 1'b0;
      m_cnt[k]  = '0;
    end else if (le >= 0 && le < HN) begin
      if (h_en[le]) begin
        ere = used_mask(h_bn[le]);
        for (int b = 0; b < 16; b++) begin
          if (ere[b]) m_addr[k][b*MA_W +: MA_W] = first_ma(h_ma[le], h_bn[le], b);
        end
        if ($countones(ere) != 16) m_conf[k] = 1'b1;
        if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
      end
      s = le - 1 - lat;
      if (s >= 0 && s > last_rst) begin
        v  = h_en[s];
        dn = h_done[s];
      end
      if (v) begin
        for (int i = 0; i < 16; i++) begin
          m_data[k][i*DATA_W +: DATA_W] =
            64'(100 + first_ma(h_ma[s], h_bn[s], int'(h_bn[s][i*BN_W +: BN_W])));
        end
        m_l[k] = h_l[s];
      end
    end
    chk($sformatf("bank_re_L%0d", lat), re, ere);
    chk($sformatf("bank_addr_L%0d", lat), addr, m_addr[k]);
    chk($sformatf("lane_valid_L%0d", lat), valid, v);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("lane_data_L%0d[%0d]", lat, i), data[i*DATA_W +: DATA_W],
          m_data[k][i*DATA_W +: DATA_W]);
    end
    chk($sformatf("lane_l_L%0d", lat), l, m_l[k]);
    chk($sformatf("done_out_L%0d", lat), done, dn);
    chk($sformatf("conflict_err_L%0d", lat), conf, m_conf[k]);
    chk($sformatf("vec_cnt_L%0d", lat), cnt, m_cnt[k]);
  endtask

  task automatic tick();
    @(negedge clk);
    check_dut(0, 1, re1, addr1, data1, valid1, l1, done1, conf1, cnt1);
    check_dut(1, 3, re3, addr3, data3, valid3, l3, done3, conf3, cnt3);
  endtask

  task automatic drive(input logic en, input logic [16*MA_W-1:0] ma,
                       input logic [16*BN_W-1:0] bn, input logic [D_W-1:0] l, input logic dn);
    in_en   = en;
    in_ma   = ma;
    in_bn   = bn;
    in_l    = l;
    in_done = dn;
  endtask

  task automatic idle();
    drive(1'b0, {$urandom, $urandom, $urandom}, {$urandom, $urandom}, D_W'($urandom), 1'b0);
  endtask

  logic [16*MA_W-1:0] vma;
  logic [16*BN_W-1:0] vbn;
  int nv, nd, hit1, hit3;

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) tick();
    chk("rst_vec_cnt", cnt1, 16'd0);
    chk("rst_lane_valid", valid1, 1'b0);
    rst = 1'b0;
    tick();

    // Identity mapping, address i+3.
    for (int i = 0; i < 16; i++) begin
      vbn[i*BN_W +: BN_W] = BN_W'(i);
      vma[i*MA_W +: MA_W] = MA_W'(i + 3);
    end
    drive(1'b1, vma, vbn, 4'd5, 1'b0);
    tick();
    chk("id_bank_re_L1", re1, 16'hFFFF);
    chk("id_bank_re_L3", re3, 16'hFFFF);
    idle();
    tick();
    tick();
    chk("id_valid_t3_L1", valid1, 1'b1);
    chk("id_lane0_L1", data1[0 +: DATA_W], 64'd103);
    chk("id_lane15_L1", data1[15*DATA_W +: DATA_W], 64'd118);
    chk("id_tag_L1", l1, 4'd5);
    chk("id_novalid_t3_L3", valid3, 1'b0);
    tick();
    tick();
    chk("id_valid_t5_L3", valid3, 1'b1);
    chk("id_lane9_L3", data3[9*DATA_W +: DATA_W], 64'd112);
    chk("id_noconflict", conf1, 1'b0);
    tick();

    // Reversed permutation, address 2i+1.
    for (int i = 0; i < 16; i++) begin
      vbn[i*BN_W +: BN_W] = BN_W'(15 - i);
      vma[i*MA_W +: MA_W] = MA_W'(2 * i + 1);
    end
    drive(1'b1, vma, vbn, 4'd9, 1'b0);
    tick();
    chk("perm_addr_b15", addr1[15*MA_W +: MA_W], 6'd1);
    chk("perm_addr_b0", addr1[0 +: MA_W], 6'd31);
    idle();
    tick();
    tick();
    chk("perm_lane0", data1[0 +: DATA_W], 64'd101);
    chk("perm_lane15", data1[15*DATA_W +: DATA_W], 64'd131);
    repeat (3) tick();

    // Lanes 2 and 7 collide on bank 5; lane 5 moves to bank 2, bank 7 idle.
    for (int i = 0; i < 16; i++) begin
      vbn[i*BN_W +: BN_W] = BN_W'(i);
      vma[i*MA_W +: MA_W] = MA_W'(i + 3);
    end
    vbn[2*BN_W +: BN_W] = 4'd5;
    vbn[7*BN_W +: BN_W] = 4'd5;
    vbn[5*BN_W +: BN_W] = 4'd2;
    vma[2*MA_W +: MA_W] = 6'd9;
    vma[7*MA_W +: MA_W] = 6'd12;
    drive(1'b1, vma, vbn, 4'd3, 1'b0);
    tick();
    chk("cf_addr_b5", addr1[5*MA_W +: MA_W], 6'd9);
    chk("cf_bank_re", re1, 16'hFF7F);
    chk("cf_flag_set", conf1, 1'b1);
    idle();
    tick();
    tick();
    chk("cf_lane2", data1[2*DATA_W +: DATA_W], 64'd109);
    chk("cf_lane7", data1[7*DATA_W +: DATA_W], 64'd109);
    chk("cf_lane5", data1[5*DATA_W +: DATA_W], 64'd108);
    repeat (4) tick();
    chk("cf_sticky_L1", conf1, 1'b1);
    chk("cf_sticky_L3", conf3, 1'b1);

    rst = 1'b1;
    tick();
    chk("cf_cleared", conf1, 1'b0);
    rst = 1'b0;
    tick();

    // 20 back-to-back vectors, in_done on the last.
    nv = 0;
    nd = 0;
    for (int k = 0; k < 28; k++) begin
      if (k < 20) begin
        for (int i = 0; i < 16; i++) begin
          vbn[i*BN_W +: BN_W] = BN_W'((i + k) % 16);
          vma[i*MA_W +: MA_W] = MA_W'((3 * i + k) % 64);
        end
        drive(1'b1, vma, vbn, D_W'(k), k == 19);
      end else begin
        idle();
      end
      tick();
      if (valid1) begin
        chk("b2b_order", l1, nv % 16);
        nv++;
      end
      if (done1) begin
        nd++;
        chk("b2b_done_on_20th", nv, 20);
        chk("b2b_done_with_valid", valid1, 1'b1);
      end
    end
    chk("b2b_pulses", nv, 20);
    chk("b2b_done_count", nd, 1);
    chk("b2b_vec_cnt_L1", cnt1, 16'd20);
    chk("b2b_vec_cnt_L3", cnt3, 16'd20);

    // Lone in_done with in_en low.
    hit1 = 0;
    hit3 = 0;
    drive(1'b0, {$urandom, $urandom, $urandom}, {$urandom, $urandom}, 4'd0, 1'b1);
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j == 1) idle();
      if (done1) hit1 = j;
      if (done3) hit3 = j;
    end
    chk("done_alone_L1", hit1, 3);
    chk("done_alone_L3", hit3, 5);

    // Reset one cycle after an accepted vector carrying in_done.
    for (int i = 0; i < 16; i++) begin
      vbn[i*BN_W +: BN_W] = BN_W'(i);
      vma[i*MA_W +: MA_W] = MA_W'(i + 3);
    end
    drive(1'b1, vma, vbn, 4'd7, 1'b1);
    tick();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_bank_re", re1, 16'd0);
    chk("mid_rst_bank_addr", addr1, '0);
    chk("mid_rst_lane_data_L1", data1[0 +: DATA_W], 64'd0);
    chk("mid_rst_lane_data_L3", data3[0 +: DATA_W], 64'd0);
    chk("mid_rst_vec_cnt", cnt1, 16'd0);
    chk("mid_rst_lane_l", l1, 4'd0);
    tick();
    rst = 1'b0;
    nv = 0;
    nd = 0;
    repeat (8) begin
      tick();
      if (valid1 || valid3) nv++;
      if (done1 || done3) nd++;
    end
    chk("mid_rst_no_valid", nv, 0);
    chk("mid_rst_no_done", nd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
